// File: rtl/mem_stage_hs_if.sv
// Bundle of the EX-side handshake, WB result, data-memory port and hazard
// signals of the memory stage. "slave" is the stage itself; "master" is the
// surrounding pipeline and memory that drive and observe it.
interface mem_stage_hs_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DEST_W = 3
);
    // EX side
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_alu_result;
    logic              in_mem_read_en;
    logic              in_mem_write_en;
    logic [DATA_W-1:0] in_mem_write_data;
    logic              in_wb_en;
    logic [DEST_W-1:0] in_wb_dest;
    logic              in_wb_mux;

    // WB side
    logic              out_valid;
    logic [DATA_W-1:0] out_alu_result;
    logic [DATA_W-1:0] out_mem_read_data;
    logic              out_wb_en;
    logic [DEST_W-1:0] out_wb_dest;
    logic              out_wb_mux;

    // Data-memory port
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    // Hazard unit
    logic [DEST_W-1:0] mem_op_dest;
    logic              mem_op_valid;
    logic              mem_load_pending;

    modport slave (
        input  in_valid, in_alu_result, in_mem_read_en, in_mem_write_en,
               in_mem_write_data, in_wb_en, in_wb_dest, in_wb_mux,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output in_ready,
        output out_valid, out_alu_result, out_mem_read_data, out_wb_en,
               out_wb_dest, out_wb_mux,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output mem_op_dest, mem_op_valid, mem_load_pending
    );

    modport master (
        output in_valid, in_alu_result, in_mem_read_en, in_mem_write_en,
               in_mem_write_data, in_wb_en, in_wb_dest, in_wb_mux,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  in_ready,
        input  out_valid, out_alu_result, out_mem_read_data, out_wb_en,
               out_wb_dest, out_wb_mux,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_op_dest, mem_op_valid, mem_load_pending
    );
endinterface

// File: rtl/mem_stage_hs.sv
// Pipeline memory stage between EX and WB. Accepts one instruction at a time
// over valid/ready, runs loads/stores on a request/grant/response memory port
// (stalling EX until done) and presents the result to WB as a one-cycle pulse.
module mem_stage_hs #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16,  // 1..DATA_W
    parameter int unsigned DEST_W = 3
) (
    input  logic           clk,
    input  logic           rst,
    mem_stage_hs_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    state_e            r_state;

    // WB result registers
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_alu_result;
    logic [DATA_W-1:0] r_out_mem_read_data;
    logic              r_out_wb_en;
    logic [DEST_W-1:0] r_out_wb_dest;
    logic              r_out_wb_mux;

    // Memory port registers; held stable from acceptance until grant
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    // Hold registers for the instruction occupying the stage
    logic [DATA_W-1:0] r_hold_alu_result;
    logic              r_hold_wb_en;
    logic [DEST_W-1:0] r_hold_wb_dest;
    logic              r_hold_wb_mux;
    logic              r_hold_read;

    logic              w_is_mem;
    logic              w_is_read;

    // A simultaneous read+write request is treated as a write
    assign w_is_mem  = bus.in_mem_read_en | bus.in_mem_write_en;
    assign w_is_read = bus.in_mem_read_en & ~bus.in_mem_write_en;

    // FSM with all outputs registered; out_valid defaults low so it only pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state             <= StIdle;
            r_out_valid         <= 1'b0;
            r_out_alu_result    <= '0;
            r_out_mem_read_data <= '0;
            r_out_wb_en         <= 1'b0;
            r_out_wb_dest       <= '0;
            r_out_wb_mux        <= 1'b0;
            r_mem_req           <= 1'b0;
            r_mem_we            <= 1'b0;
            r_mem_addr          <= '0;
            r_mem_wdata         <= '0;
            r_hold_alu_result   <= '0;
            r_hold_wb_en        <= 1'b0;
            r_hold_wb_dest      <= '0;
            r_hold_wb_mux       <= 1'b0;
            r_hold_read         <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (bus.in_valid) begin
                        if (w_is_mem) begin
                            r_hold_alu_result <= bus.in_alu_result;
                            r_hold_wb_en      <= bus.in_wb_en;
                            r_hold_wb_dest    <= bus.in_wb_dest;
                            r_hold_wb_mux     <= bus.in_wb_mux;
                            r_hold_read       <= w_is_read;
                            r_mem_req         <= 1'b1;
                            r_mem_we          <= bus.in_mem_write_en;
                            r_mem_addr        <= bus.in_alu_result[ADDR_W-1:0];
                            r_mem_wdata       <= bus.in_mem_write_data;
                            r_state           <= StReq;
                        end else begin
                            r_out_valid         <= 1'b1;
                            r_out_alu_result    <= bus.in_alu_result;
                            r_out_mem_read_data <= '0;
                            r_out_wb_en         <= bus.in_wb_en;
                            r_out_wb_dest       <= bus.in_wb_dest;
                            r_out_wb_mux        <= bus.in_wb_mux;
                        end
                    end
                end
                StReq: begin
                    if (bus.mem_gnt) begin
                        r_mem_req <= 1'b0;
                        if (r_hold_read) begin
                            r_state <= StResp;
                        end else begin
                            // Stores complete on grant
                            r_out_valid         <= 1'b1;
                            r_out_alu_result    <= r_hold_alu_result;
                            r_out_mem_read_data <= '0;
                            r_out_wb_en         <= r_hold_wb_en;
                            r_out_wb_dest       <= r_hold_wb_dest;
                            r_out_wb_mux        <= r_hold_wb_mux;
                            r_state             <= StIdle;
                        end
                    end
                end
                StResp: begin
                    if (bus.mem_rvalid) begin
                        r_out_valid         <= 1'b1;
                        r_out_alu_result    <= r_hold_alu_result;
                        r_out_mem_read_data <= bus.mem_rdata;
                        r_out_wb_en         <= r_hold_wb_en;
                        r_out_wb_dest       <= r_hold_wb_dest;
                        r_out_wb_mux        <= r_hold_wb_mux;
                        r_state             <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.in_ready          = (r_state == StIdle);
    assign bus.out_valid         = r_out_valid;
    assign bus.out_alu_result    = r_out_alu_result;
    assign bus.out_mem_read_data = r_out_mem_read_data;
    assign bus.out_wb_en         = r_out_wb_en;
    assign bus.out_wb_dest       = r_out_wb_dest;
    assign bus.out_wb_mux        = r_out_wb_mux;
    assign bus.mem_req           = r_mem_req;
    assign bus.mem_we            = r_mem_we;
    assign bus.mem_addr          = r_mem_addr;
    assign bus.mem_wdata         = r_mem_wdata;

    // Hazard info: look through to EX while idle, otherwise report the held op
    always_comb begin
        bus.mem_op_dest      = bus.in_wb_dest;
        bus.mem_op_valid     = bus.in_valid & bus.in_wb_en;
        bus.mem_load_pending = bus.in_valid & w_is_read;
        if (r_state != StIdle) begin
            bus.mem_op_dest      = r_hold_wb_dest;
            bus.mem_op_valid     = r_hold_wb_en;
            bus.mem_load_pending = r_hold_read;
        end
    end

endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed bench for mem_stage_hs: default 16-bit instance plus a 32/12-bit
// instance for the address-truncation case.
module tb_mem_stage_hs;

    logic clk;
    logic rst;

    int n_checks;
    int n_bad;

    mem_stage_hs_if #(.DATA_W(16), .ADDR_W(16), .DEST_W(3)) bus ();
    mem_stage_hs_if #(.DATA_W(32), .ADDR_W(12), .DEST_W(3)) wbus ();

    mem_stage_hs #(.DATA_W(16), .ADDR_W(16), .DEST_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    mem_stage_hs #(.DATA_W(32), .ADDR_W(12), .DEST_W(3)) dut_w (
        .clk (clk),
        .rst (rst),
        .bus (wbus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid = 0; bus.in_alu_result = '0; bus.in_mem_read_en = 0;
        bus.in_mem_write_en = 0; bus.in_mem_write_data = '0; bus.in_wb_en = 0;
        bus.in_wb_dest = '0; bus.in_wb_mux = 0;
        bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;
        wbus.in_valid = 0; wbus.in_alu_result = '0; wbus.in_mem_read_en = 0;
        wbus.in_mem_write_en = 0; wbus.in_mem_write_data = '0; wbus.in_wb_en = 0;
        wbus.in_wb_dest = '0; wbus.in_wb_mux = 0;
        wbus.mem_gnt = 0; wbus.mem_rvalid = 0; wbus.mem_rdata = '0;
    endtask

    task automatic test_reset();
        rst = 0;
        step();
        step();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_bad++;
            $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        n_checks++; if (bus.mem_req !== 1'b0) begin n_bad++;
            $display("FAIL reset_mem_req got=%b want=0", bus.mem_req); end
        n_checks++; if (bus.out_alu_result !== 16'h0) begin n_bad++;
            $display("FAIL reset_out_alu got=%h want=0000", bus.out_alu_result); end
        n_checks++; if (bus.mem_addr !== 16'h0) begin n_bad++;
            $display("FAIL reset_mem_addr got=%h want=0000", bus.mem_addr); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_bad++;
            $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
        rst = 1;
        step();
    endtask

    task automatic test_alu();
        bus.in_valid = 1; bus.in_alu_result = 16'h1234; bus.in_wb_en = 1;
        bus.in_wb_dest = 3'd5; bus.in_wb_mux = 0;
        #1;
        n_checks++; if (bus.mem_op_valid !== 1'b1 || bus.mem_op_dest !== 3'd5) begin n_bad++;
            $display("FAIL alu_hazard got=%b/%0d want=1/5", bus.mem_op_valid, bus.mem_op_dest); end
        step();
        bus.in_valid = 0;
        n_checks++; if (bus.out_valid !== 1'b1) begin n_bad++;
            $display("FAIL alu_out_valid got=%b want=1", bus.out_valid); end
        n_checks++; if (bus.out_alu_result !== 16'h1234) begin n_bad++;
            $display("FAIL alu_out_alu got=%h want=1234", bus.out_alu_result); end
        n_checks++; if (bus.out_wb_dest !== 3'd5 || bus.out_wb_en !== 1'b1) begin n_bad++;
            $display("FAIL alu_out_wb got=%0d/%b want=5/1", bus.out_wb_dest, bus.out_wb_en); end
        n_checks++; if (bus.out_mem_read_data !== 16'h0) begin n_bad++;
            $display("FAIL alu_out_rdata got=%h want=0000", bus.out_mem_read_data); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_bad++;
            $display("FAIL alu_in_ready got=%b want=1", bus.in_ready); end
        step();
        n_checks++; if (bus.out_valid !== 1'b0 || bus.out_alu_result !== 16'h1234) begin
            n_bad++;
            $display("FAIL alu_pulse_hold got=%b/%h want=0/1234",
                     bus.out_valid, bus.out_alu_result); end
    endtask

    task automatic test_store();
        idle_inputs();
        bus.in_valid = 1; bus.in_alu_result = 16'h0040; bus.in_mem_write_en = 1;
        bus.in_mem_write_data = 16'hBEEF; bus.in_wb_en = 0;
        step();
        bus.in_valid = 0; bus.in_alu_result = 16'h5555; bus.in_mem_write_data = 16'h1111;
        bus.in_mem_write_en = 0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 16'h0040 ||
                bus.mem_wdata !== 16'hBEEF) begin
                n_bad++;
                $display("FAIL store_req_c%0d got=req%b we%b a%h d%h want=req1 we1 a0040 dBEEF",
                         i, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata);
            end
            n_checks++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL store_stall_c%0d got=rdy%b ov%b want=rdy0 ov0",
                         i, bus.in_ready, bus.out_valid);
            end
            if (i == 3) bus.mem_gnt = 1;
            step();
        end
        bus.mem_gnt = 0;
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_mem_read_data !== 16'h0) begin n_bad++;
            $display("FAIL store_done got=ov%b rd%h want=ov1 rd0000",
                     bus.out_valid, bus.out_mem_read_data); end
        n_checks++; if (bus.mem_req !== 1'b0 || bus.in_ready !== 1'b1) begin n_bad++;
            $display("FAIL store_release got=req%b rdy%b want=req0 rdy1",
                     bus.mem_req, bus.in_ready); end
        step();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_bad++;
            $display("FAIL store_pulse got=%b want=0", bus.out_valid); end
    endtask

    task automatic test_load();
        idle_inputs();
        bus.in_valid = 1; bus.in_alu_result = 16'h0010; bus.in_mem_read_en = 1;
        bus.in_wb_en = 1; bus.in_wb_dest = 3'd3; bus.in_wb_mux = 1;
        #1;
        n_checks++; if (bus.mem_load_pending !== 1'b1) begin n_bad++;
            $display("FAIL load_pend_t got=%b want=1", bus.mem_load_pending); end
        step();
        idle_inputs();
        // Grant now; an rvalid in the grant cycle must be ignored
        bus.mem_gnt = 1; bus.mem_rvalid = 1; bus.mem_rdata = 16'hDEAD;
        n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 ||
                        bus.mem_addr !== 16'h0010) begin n_bad++;
            $display("FAIL load_req got=req%b we%b a%h want=req1 we0 a0010",
                     bus.mem_req, bus.mem_we, bus.mem_addr); end
        n_checks++; if (bus.mem_load_pending !== 1'b1 || bus.mem_op_dest !== 3'd3) begin
            n_bad++;
            $display("FAIL load_pend_req got=%b/%0d want=1/3",
                     bus.mem_load_pending, bus.mem_op_dest); end
        step();
        bus.mem_gnt = 0; bus.mem_rvalid = 0;
        n_checks++; if (bus.mem_req !== 1'b0 || bus.out_valid !== 1'b0 ||
                        bus.mem_load_pending !== 1'b1) begin n_bad++;
            $display("FAIL load_resp1 got=req%b ov%b pend%b want=req0 ov0 pend1",
                     bus.mem_req, bus.out_valid, bus.mem_load_pending); end
        step();
        bus.mem_rvalid = 1; bus.mem_rdata = 16'hCAFE;
        n_checks++; if (bus.out_valid !== 1'b0 || bus.mem_load_pending !== 1'b1) begin
            n_bad++;
            $display("FAIL load_resp2 got=ov%b pend%b want=ov0 pend1",
                     bus.out_valid, bus.mem_load_pending); end
        step();
        bus.mem_rvalid = 0; bus.mem_rdata = '0;
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_mem_read_data !== 16'hCAFE) begin
            n_bad++;
            $display("FAIL load_data got=ov%b rd%h want=ov1 rdCAFE",
                     bus.out_valid, bus.out_mem_read_data); end
        n_checks++; if (bus.out_wb_mux !== 1'b1 || bus.out_wb_dest !== 3'd3 ||
                        bus.out_alu_result !== 16'h0010) begin n_bad++;
            $display("FAIL load_wb got=mux%b d%0d alu%h want=mux1 d3 alu0010",
                     bus.out_wb_mux, bus.out_wb_dest, bus.out_alu_result); end
        n_checks++; if (bus.mem_load_pending !== 1'b0) begin n_bad++;
            $display("FAIL load_pend_end got=%b want=0", bus.mem_load_pending); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] vals [4];
        vals[0] = 16'h0001; vals[1] = 16'h00A5; vals[2] = 16'h7FFF; vals[3] = 16'hFFFF;
        idle_inputs();
        step();
        bus.in_valid = 1; bus.in_wb_en = 1; bus.in_alu_result = vals[0]; bus.in_wb_dest = 3'd1;
        for (int i = 0; i < 4; i++) begin
            bus.mem_rvalid = (i == 1); bus.mem_rdata = 16'hBAD0;
            step();
            if (i < 3) begin
                bus.in_alu_result = vals[i+1]; bus.in_wb_dest = 3'(i + 2);
            end else begin
                bus.in_valid = 0;
            end
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_alu_result !== vals[i] ||
                bus.out_wb_dest !== 3'(i + 1) || bus.out_mem_read_data !== 16'h0) begin
                n_bad++;
                $display("FAIL b2b_%0d got=ov%b alu%h d%0d rd%h want=ov1 alu%h d%0d rd0000",
                         i, bus.out_valid, bus.out_alu_result, bus.out_wb_dest,
                         bus.out_mem_read_data, vals[i], i + 1);
            end
        end
        bus.mem_rvalid = 0;
        step();
        n_checks++; if (bus.out_valid !== 1'b0 || bus.mem_req !== 1'b0) begin n_bad++;
            $display("FAIL b2b_end got=ov%b req%b want=ov0 req0", bus.out_valid, bus.mem_req); end
    endtask

    task automatic test_reset_resp();
        idle_inputs();
        bus.in_valid = 1; bus.in_alu_result = 16'h0020; bus.in_mem_read_en = 1;
        bus.in_wb_en = 1; bus.in_wb_dest = 3'd6; bus.in_wb_mux = 1;
        step();
        idle_inputs();
        bus.mem_gnt = 1;
        step();
        bus.mem_gnt = 0;
        // Now in RESP; reset mid-cycle
        rst = 0;
        #1;
        n_checks++; if (bus.mem_req !== 1'b0 || bus.out_valid !== 1'b0 ||
                        bus.out_alu_result !== 16'h0 || bus.out_wb_dest !== 3'd0 ||
                        bus.out_wb_en !== 1'b0) begin n_bad++;
            $display("FAIL rst_resp_clear got=req%b ov%b alu%h d%0d en%b want=all 0",
                     bus.mem_req, bus.out_valid, bus.out_alu_result, bus.out_wb_dest,
                     bus.out_wb_en); end
        n_checks++; if (bus.in_ready !== 1'b1 || bus.mem_load_pending !== 1'b0) begin n_bad++;
            $display("FAIL rst_resp_state got=rdy%b pend%b want=rdy1 pend0",
                     bus.in_ready, bus.mem_load_pending); end
        step();
        rst = 1;
        bus.mem_rvalid = 1; bus.mem_rdata = 16'h7777;
        for (int i = 0; i < 3; i++) begin
            step();
            bus.mem_rvalid = 0;
            n_checks++;
            if (bus.out_valid !== 1'b0 || bus.out_mem_read_data !== 16'h0) begin
                n_bad++;
                $display("FAIL rst_late_rvalid_%0d got=ov%b rd%h want=ov0 rd0000",
                         i, bus.out_valid, bus.out_mem_read_data);
            end
        end
    endtask

    task automatic test_wide();
        idle_inputs();
        wbus.in_valid = 1; wbus.in_alu_result = 32'hFFFF_F123; wbus.in_mem_read_en = 1;
        wbus.in_wb_en = 1; wbus.in_wb_dest = 3'd7; wbus.in_wb_mux = 1;
        step();
        idle_inputs();
        wbus.mem_gnt = 1;
        n_checks++; if (wbus.mem_req !== 1'b1 || wbus.mem_addr !== 12'h123) begin n_bad++;
            $display("FAIL wide_addr got=req%b a%h want=req1 a123",
                     wbus.mem_req, wbus.mem_addr); end
        step();
        wbus.mem_gnt = 0; wbus.mem_rvalid = 1; wbus.mem_rdata = 32'h89AB_CDEF;
        step();
        wbus.mem_rvalid = 0;
        n_checks++; if (wbus.out_valid !== 1'b1 || wbus.out_mem_read_data !== 32'h89AB_CDEF) begin
            n_bad++;
            $display("FAIL wide_rdata got=ov%b rd%h want=ov1 rd89abcdef",
                     wbus.out_valid, wbus.out_mem_read_data); end
        n_checks++; if (wbus.out_alu_result !== 32'hFFFF_F123) begin n_bad++;
            $display("FAIL wide_alu got=%h want=fffff123", wbus.out_alu_result); end
    endtask

    initial begin
        n_checks = 0;
        n_bad    = 0;
        rst      = 0;
        idle_inputs();
        test_reset();
        test_alu();
        test_store();
        test_load();
        test_back_to_back();
        test_reset_resp();
        test_wide();
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_stage_hs.md
Name: mem_stage_hs

Overview:
- Parametrised successor to the fixed-width MIPS-16 memory stage.
- Sits between EX and WB with a valid/ready handshake on the EX side.
- Drives a variable-latency request/grant/response data-memory port, so it stalls the pipeline on slow memory.
- Registers the result for WB as a single-cycle valid pulse.
- Exports destination and pending-load information to the hazard unit.

Parameters:
DATA_W, 16, datapath width (ALU result, store data, load data)
ADDR_W, 16, memory address width; legal range 1..DATA_W
DEST_W, 3, register-file index width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
in_valid  in  1  EX presents an instruction
in_ready  out  1  stage accepts the instruction this cycle
in_alu_result  in  DATA_W  ALU result / memory address
in_mem_read_en  in  1  load
in_mem_write_en  in  1  store
in_mem_write_data  in  DATA_W  store data
in_wb_en  in  1  write-back enable
in_wb_dest  in  DEST_W  write-back register
in_wb_mux  in  1  write-back select (0 = ALU, 1 = memory)
out_valid  out  1  one-cycle pulse: WB fields valid
out_alu_result  out  DATA_W  registered ALU result
out_mem_read_data  out  DATA_W  registered load data; 0 for non-loads
out_wb_en  out  1  registered
out_wb_dest  out  DEST_W  registered
out_wb_mux  out  1  registered
mem_req  out  1  memory request
mem_we  out  1  1 = write
mem_addr  out  ADDR_W  address, equal to alu_result[ADDR_W-1:0]
mem_wdata  out  DATA_W  store data
mem_gnt  in  1  request accepted
mem_rvalid  in  1  read data valid
mem_rdata  in  DATA_W  read data
mem_op_dest  out  DEST_W  destination of the instruction occupying the stage
mem_op_valid  out  1  mem_op_dest is meaningful and wb_en is set
mem_load_pending  out  1  a load is in flight; dest not yet available

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All out_* = 0, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, hold registers = 0.
  - An in-flight operation is discarded; no out_valid is generated for it.
- FSM states: IDLE, REQ, RESP. in_ready = 1 only in IDLE.
- Acceptance: an instruction is accepted when in_valid and in_ready are both 1 at a clock edge (cycle t).
- IDLE, accepted, no memory op: out_* load from the inputs at edge t; out_valid = 1 during cycle t+1. State stays IDLE, so back-to-back acceptance gives out_valid on consecutive cycles.
- IDLE, accepted, read or write set:
  - Latch addr, we, wdata, wb fields into hold registers; go to REQ.
  - mem_req is registered and goes to 1 in cycle t+1.
  - If read and write are both set, the op is a write and the loaded data is 0.
- REQ:
  - mem_req = 1; mem_we, mem_addr and mem_wdata are stable until grant.
  - mem_gnt sampled at cycle g:
    - Write: out_valid in cycle g+1, out_mem_read_data = 0, return to IDLE.
    - Read: go to RESP; mem_req = 0 from g+1.
- RESP: wait for mem_rvalid sampled at cycle r ≥ g+1. Capture mem_rdata into out_mem_read_data; out_valid in cycle r+1; return to IDLE.
- mem_rvalid in IDLE or REQ is ignored. mem_rvalid in the grant cycle itself is ignored.
- out_valid is a one-cycle pulse. out_* data holds its last value between pulses.
- Minimum latency from acceptance to out_valid:
  - Non-mem op: 1 cycle.
  - Write: 2 cycles (immediate grant).
  - Read: 3 cycles (immediate grant, rvalid on the next cycle).
- Hazard outputs:
  - In IDLE: mem_op_dest = in_wb_dest; mem_op_valid = in_valid & in_wb_en; mem_load_pending = in_valid & in_mem_read_en & ~in_mem_write_en.
  - In REQ/RESP: outputs are taken from the hold registers; mem_load_pending = 1 iff the held op is a read.
- Width rule: mem_addr truncates the ALU result to its low ADDR_W bits; no sign extension anywhere.

Test Plan:
- Reset then release; ALU op with in_alu_result=0x1234, dest=5, wb_en=1 at cycle t -> out_valid at t+1; out_alu_result=0x1234, out_wb_dest=5, out_mem_read_data=0; in_ready stays 1.
- Store addr=0x0040, data=0xBEEF, mem_gnt held off 3 cycles -> mem_req=1 for 4 cycles with stable addr/data, mem_we=1; in_ready=0 throughout; out_valid exactly 1 cycle after the grant.
- Load addr=0x0010, grant immediately, rvalid 2 cycles later with 0xCAFE -> out_mem_read_data=0xCAFE, out_wb_mux=1; mem_load_pending=1 from acceptance until the out_valid cycle.
- Four back-to-back ALU ops on consecutive cycles -> four consecutive out_valid pulses with matching data; a stray mem_rvalid in IDLE has no effect.
- Assert rst low during RESP -> mem_req=0 and all out_*=0 immediately; a late rvalid is ignored; no out_valid after rst returns high.
- DATA_W=32, ADDR_W=12, load from alu_result 0xFFFF_F123 -> mem_addr=0x123; 32-bit rdata 0x89AB_CDEF returned intact.
